// File: rtl/pwm_encoder_mixer.sv
// Purpose: per-channel quadrature decoder (sync + debounce) driving duty registers, mixed onto a shared-counter PWM.
// Latency: stable encoder level reaches value_out DEBOUNCE_LEN+3 clocks after first sample; load_val lands next clock.
// Backpressure: none; every input is sampled each clock and nothing can stall.
module pwm_encoder_mixer #(
   parameter int CHANNELS     = 3,
   parameter int WIDTH        = 8,
   parameter int DEBOUNCE_LEN = 8
) (
   input  logic                      clock,
   input  logic                      resetb,
   input  logic [CHANNELS-1:0]       enc_a,
   input  logic [CHANNELS-1:0]       enc_b,
   input  logic                      mode_sat,
   input  logic                      load_en,
   input  logic [7:0]                load_ch,
   input  logic [WIDTH-1:0]          load_val,
   output logic [CHANNELS*WIDTH-1:0] value_out,
   output logic [CHANNELS-1:0]       pwm_out
);

   logic [CHANNELS-1:0]     a_s1, a_s2, b_s1, b_s2;
   logic [DEBOUNCE_LEN-1:0] a_sr [CHANNELS];
   logic [DEBOUNCE_LEN-1:0] b_sr [CHANNELS];
   logic [CHANNELS-1:0]     a_deb, b_deb, a_prev, b_prev;
   logic [CHANNELS-1:0]     step_up, step_dn, load_hit;
   logic [WIDTH-1:0]        value      [CHANNELS];
   logic [WIDTH-1:0]        value_nxt  [CHANNELS];
   logic [WIDTH-1:0]        shadow     [CHANNELS];
   logic [WIDTH-1:0]        cnt;

   // Two-flop synchronisers for the asynchronous encoder pins.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         a_s1 <= '0;
         a_s2 <= '0;
         b_s1 <= '0;
         b_s2 <= '0;
      end else begin
         a_s1 <= enc_a;
         a_s2 <= a_s1;
         b_s1 <= enc_b;
         b_s2 <= b_s1;
      end
   end

   // Debounce: level only moves once the whole sample window agrees, then previous level is kept for edge decode.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < CHANNELS; i++) begin
            a_sr[i] <= '0;
            b_sr[i] <= '0;
         end
         a_deb  <= '0;
         b_deb  <= '0;
         a_prev <= '0;
         b_prev <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            a_sr[i] <= (a_sr[i] << 1) | DEBOUNCE_LEN'(a_s2[i]);
            b_sr[i] <= (b_sr[i] << 1) | DEBOUNCE_LEN'(b_s2[i]);
            if (&a_sr[i])
               a_deb[i] <= 1'b1;
            else if (~|a_sr[i])
               a_deb[i] <= 1'b0;
            if (&b_sr[i])
               b_deb[i] <= 1'b1;
            else if (~|b_sr[i])
               b_deb[i] <= 1'b0;
         end
         a_prev <= a_deb;
         b_prev <= b_deb;
      end
   end

   // Quadrature decode of {prev a,b} -> {cur a,b}; idle and two-bit jumps produce no step.
   always_comb begin
      step_up = '0;
      step_dn = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         case ({a_prev[i], b_prev[i], a_deb[i], b_deb[i]})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: step_up[i] = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: step_dn[i] = 1'b1;
            default: ;
         endcase
      end
   end

   // Next duty value: a direct load wins over an encoder step on the same channel; steps wrap or clamp per mode_sat.
   always_comb begin
      load_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         value_nxt[i] = value[i];
         load_hit[i]  = load_en && (load_ch == 8'(i));
         if (load_hit[i])
            value_nxt[i] = load_val;
         else if (step_up[i]) begin
            if (!(mode_sat && (value[i] == {WIDTH{1'b1}})))
               value_nxt[i] = value[i] + WIDTH'(1);
         end else if (step_dn[i]) begin
            if (!(mode_sat && (value[i] == '0)))
               value_nxt[i] = value[i] - WIDTH'(1);
         end
      end
   end

   // Duty value registers.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < CHANNELS; i++)
            value[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            value[i] <= value_nxt[i];
      end
   end

   // Pack per-channel duty values onto the flat output bus.
   always_comb begin
      value_out = '0;
      for (int i = 0; i < CHANNELS; i++)
         value_out[i*WIDTH +: WIDTH] = value[i];
   end

   // Shared PWM counter; shadow duties refresh only at the period boundary so a period never mixes duties.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         cnt     <= '0;
         pwm_out <= '0;
         for (int i = 0; i < CHANNELS; i++)
            shadow[i] <= '0;
      end else begin
         cnt <= cnt + WIDTH'(1);
         for (int i = 0; i < CHANNELS; i++) begin
            if (cnt == {WIDTH{1'b1}})
               shadow[i] <= value[i];
            pwm_out[i] <= (cnt < shadow[i]);
         end
      end
   end

endmodule

// File: tb/tb_pwm_encoder_mixer.sv
// Purpose: directed checks of decode, wrap/saturate, loads, debounce latency, PWM duty and async reset.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_pwm_encoder_mixer;
   localparam int CH = 3;
   localparam int W  = 8;
   localparam int DL = 8;

   logic            clock = 1'b0;
   logic            resetb;
   logic [CH-1:0]   enc_a, enc_b;
   logic            mode_sat, load_en;
   logic [7:0]      load_ch;
   logic [W-1:0]    load_val;
   logic [CH*W-1:0] value_out;
   logic [CH-1:0]   pwm_out;

   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] tb_cnt;
   int          idx [CH];
   int          hi  [CH];

   typedef struct {
      logic        msat;
      logic        ld;
      logic [7:0]  lch;
      logic [7:0]  lval;
      int          sch;
      int          sdir;
      logic [23:0] exp;
   } vec_t;
   vec_t vecs [15];

   always #5 clock = ~clock;

   pwm_encoder_mixer #(.CHANNELS(CH), .WIDTH(W), .DEBOUNCE_LEN(DL)) dut (
      .clock     (clock),
      .resetb    (resetb),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .mode_sat  (mode_sat),
      .load_en   (load_en),
      .load_ch   (load_ch),
      .load_val  (load_val),
      .value_out (value_out),
      .pwm_out   (pwm_out)
   );

   // Reference copy of the free-running period counter, used only to align duty-count windows.
   always @(posedge clock or negedge resetb) begin
      if (!resetb) tb_cnt <= '0;
      else         tb_cnt <= tb_cnt + 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Gray sequence 00 -> 10 -> 11 -> 01 is the +1 direction.
   task automatic step(input int ch, input int dir);
      idx[ch]   = (idx[ch] + dir + 4) % 4;
      enc_a[ch] = (idx[ch] == 1) || (idx[ch] == 2);
      enc_b[ch] = (idx[ch] == 2) || (idx[ch] == 3);
   endtask

   task automatic load_pulse(input logic [7:0] ch, input logic [7:0] v);
      load_en  = 1'b1;
      load_ch  = ch;
      load_val = v;
      tick(1);
      load_en  = 1'b0;
      tick(1);
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (tb_cnt != 0 && n < 300);
      check("period_align", 32'(tb_cnt), 32'd0);
   endtask

   // Counts high cycles over one full period; optionally loads ch0 partway through.
   task automatic count_period(input int load_at, input logic [7:0] lv);
      for (int c = 0; c < CH; c++) hi[c] = 0;
      for (int i = 0; i < 256; i++) begin
         if (i == load_at) begin
            load_en  = 1'b1;
            load_ch  = 8'd0;
            load_val = lv;
         end else begin
            load_en = 1'b0;
         end
         tick(1);
         for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
      end
      load_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      //            msat  ld    lch    lval   sch sdir exp {ch2,ch1,ch0}
      vecs[0]  = '{1'b0, 1'b0, 8'd0, 8'h00, 0,  1, 24'h000001};
      vecs[1]  = '{1'b0, 1'b0, 8'd0, 8'h00, 0,  1, 24'h000002};
      vecs[2]  = '{1'b0, 1'b0, 8'd0, 8'h00, 0,  1, 24'h000003};
      vecs[3]  = '{1'b0, 1'b0, 8'd0, 8'h00, 0,  1, 24'h000004};
      vecs[4]  = '{1'b1, 1'b1, 8'd1, 8'hFF, 0,  0, 24'h00FF04};
      vecs[5]  = '{1'b1, 1'b0, 8'd0, 8'h00, 1,  1, 24'h00FF04};
      vecs[6]  = '{1'b0, 1'b0, 8'd0, 8'h00, 0,  0, 24'h00FF04};
      vecs[7]  = '{1'b0, 1'b0, 8'd0, 8'h00, 1,  1, 24'h000004};
      vecs[8]  = '{1'b1, 1'b0, 8'd0, 8'h00, 2, -1, 24'h000004};
      vecs[9]  = '{1'b0, 1'b0, 8'd0, 8'h00, 2, -1, 24'hFF0004};
      vecs[10] = '{1'b1, 1'b0, 8'd0, 8'h00, 2,  1, 24'hFF0004};
      vecs[11] = '{1'b0, 1'b0, 8'd0, 8'h00, 2,  1, 24'h000004};
      vecs[12] = '{1'b0, 1'b0, 8'd0, 8'h00, 0, -1, 24'h000003};
      vecs[13] = '{1'b0, 1'b1, 8'd5, 8'h11, 0,  0, 24'h000003};
      vecs[14] = '{1'b0, 1'b1, 8'd2, 8'h80, 0,  0, 24'h800003};

      resetb   = 1'b0;
      enc_a    = '0;
      enc_b    = '0;
      mode_sat = 1'b0;
      load_en  = 1'b0;
      load_ch  = '0;
      load_val = '0;
      for (int c = 0; c < CH; c++) idx[c] = 0;

      #12;
      check("reset_value", 32'(value_out), 32'd0);
      check("reset_pwm", 32'(pwm_out), 32'd0);
      #1 resetb = 1'b1;
      tick(2);
      check("post_reset_value", 32'(value_out), 32'd0);

      for (int v = 0; v < 15; v++) begin
         mode_sat = vecs[v].msat;
         if (vecs[v].ld) load_pulse(vecs[v].lch, vecs[v].lval);
         if (vecs[v].sdir != 0) begin
            step(vecs[v].sch, vecs[v].sdir);
            tick(20);
         end else begin
            tick(2);
         end
         check($sformatf("vec%0d", v), 32'(value_out), 32'(vecs[v].exp));
      end

      // Exact pin-to-value latency on ch1 (+1 from 11 to 01).
      step(1, 1);
      tick(DL + 3);
      check("latency_early", 32'(value_out), 32'h800003);
      tick(1);
      check("latency_exact", 32'(value_out), 32'h800103);

      // Bouncing ch0 phase A never settles long enough to count.
      for (int k = 0; k < 33; k++) begin
         enc_a[0] = ~enc_a[0];
         tick(3);
      end
      enc_a[0] = 1'b0;
      tick(20);
      check("bounce_ignored", 32'(value_out), 32'h800103);

      // Load on ch1 lands on the same edge as ch1 and ch0 steps: ch1 takes load, ch0 still steps.
      step(0, 1);
      step(1, 1);
      tick(DL + 3);
      load_en  = 1'b1;
      load_ch  = 8'd1;
      load_val = 8'h5A;
      tick(1);
      load_en  = 1'b0;
      tick(20);
      check("load_beats_step", 32'(value_out), 32'h805A04);
      load_pulse(8'd5, 8'hEE);
      check("load_out_of_range", 32'(value_out), 32'h805A04);

      // PWM duty: 64 on ch0, full-scale on ch1, zero on ch2.
      load_pulse(8'd0, 8'd64);
      load_pulse(8'd1, 8'd255);
      load_pulse(8'd2, 8'd0);
      check("pwm_values", 32'(value_out), 32'h00FF40);
      wait_start();
      count_period(-1, 8'd0);
      check("p1_ch0", 32'(hi[0]), 32'd64);
      check("p1_ch1", 32'(hi[1]), 32'd255);
      check("p1_ch2", 32'(hi[2]), 32'd0);
      count_period(100, 8'd128);
      check("p2_ch0_keeps_old", 32'(hi[0]), 32'd64);
      check("p2_value", 32'(value_out), 32'h00FF80);
      count_period(-1, 8'd0);
      check("p3_ch0_new", 32'(hi[0]), 32'd128);
      check("p3_ch1", 32'(hi[1]), 32'd255);
      check("p3_ch2", 32'(hi[2]), 32'd0);

      // Asynchronous reset in mid-period clears outputs before any edge.
      tick(10);
      check("pwm_mid_period", 32'(pwm_out), 32'b011);
      #2 resetb = 1'b0;
      #1;
      check("async_reset_pwm", 32'(pwm_out), 32'd0);
      check("async_reset_value", 32'(value_out), 32'd0);
      resetb = 1'b1;
      tick(20);
      check("after_reset_value", 32'(value_out), 32'd0);
      check("after_reset_pwm", 32'(pwm_out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
